// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
// SECDED decoder stage that sits after hamming_parity (decode mode). It takes a
// received codeword together with its syndrome and extended parity, corrects a
// single-bit error, flags an uncorrectable (double) error and extracts the payload.
// Two registered stages with a valid/ready handshake; one beat per cycle.
// Optional error counters are built when the macro HAMMING_ERR_COUNT_EN is defined.
module hamming_secded_decoder #(
  parameter int DATA_WIDTH = 32,
`ifdef HAMMING_ERR_COUNT_EN
  parameter int CNT_WIDTH = 16,
`endif
  // Smallest r with 2**r >= DATA_WIDTH+r+1, reached by two fixed-point steps
  localparam int ADDR_PRE    = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH) + 1),
  localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + ADDR_PRE + 1),
  localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [CODED_WIDTH-1:0] code_i,
  input  logic [ADDR_WIDTH-1:0]  syndrome_i,
  input  logic                   ext_parity_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   err_single_o,
`ifdef HAMMING_ERR_COUNT_EN
  input  logic                   cnt_clear_i,
  output logic [CNT_WIDTH-1:0]   single_cnt_o,
  output logic [CNT_WIDTH-1:0]   double_cnt_o,
`endif
  output logic                   err_double_o
);

  // Payload bits live at every non-power-of-two position from 3 upwards, in order
  function automatic logic [DATA_WIDTH-1:0] extract_payload(input logic [CODED_WIDTH-1:0] code);
    logic [DATA_WIDTH-1:0] payload;
    int k;
    payload = '0;
    k = 0;
    for (int p = 3; p < CODED_WIDTH; p++) begin
      if ((p & (p - 1)) != 0) begin
        payload[k] = code[p];
        k++;
      end
    end
    return payload;
  endfunction

  logic                   s1_v;
  logic [CODED_WIDTH-1:0] s1_code;
  logic [ADDR_WIDTH-1:0]  s1_syn;
  logic                   s1_p;
  logic                   s2_v;

  logic                   accept;
  logic                   s2_free;
  logic                   s2_load;

  logic                   fix_single;
  logic                   fix_double;
  logic [CODED_WIDTH-1:0] fixed_code;
  logic [DATA_WIDTH-1:0]  fixed_data;
  logic                   unused_parity_bits;

  // Stage 2 can take a beat when empty or when its beat leaves this cycle;
  // stage 1 likewise, where "leaving" means moving into stage 2.
  assign s2_free     = !s2_v || out_ready_i;
  assign s2_load     = s1_v && s2_free;
  assign in_ready_o  = !s1_v || s2_free;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = s2_v;

  // Classify the captured beat and build the corrected payload
  always_comb begin
    fix_single = s1_p && (int'(s1_syn) < CODED_WIDTH);
    fix_double = s1_p ? !fix_single : (s1_syn != '0);
    fixed_code = s1_code ^ ({{(CODED_WIDTH-1){1'b0}}, fix_single} << s1_syn);
    fixed_data = extract_payload(fixed_code);
  end

  // Parity positions are consumed by the syndrome upstream, not by the payload
  assign unused_parity_bits = ^fixed_code;

  // Stage 1: capture the received codeword, syndrome and overall parity check
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v    <= 1'b0;
      s1_code <= '0;
      s1_syn  <= '0;
      s1_p    <= 1'b0;
    end else if (accept) begin
      s1_v    <= 1'b1;
      s1_code <= code_i;
      s1_syn  <= syndrome_i;
      s1_p    <= ext_parity_i ^ code_i[0];
    end else if (s2_load) begin
      s1_v    <= 1'b0;
    end
  end

  // Stage 2: registered result; flags drop whenever the stage empties
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_v         <= 1'b0;
      data_o       <= '0;
      err_single_o <= 1'b0;
      err_double_o <= 1'b0;
    end else if (s2_load) begin
      s2_v         <= 1'b1;
      data_o       <= fixed_data;
      err_single_o <= fix_single;
      err_double_o <= fix_double;
    end else if (out_ready_i) begin
      s2_v         <= 1'b0;
      err_single_o <= 1'b0;
      err_double_o <= 1'b0;
    end
  end

`ifdef HAMMING_ERR_COUNT_EN
  logic out_fire;
  assign out_fire = s2_v && out_ready_i;

  // Saturating error counters bumped on each delivered flagged beat; clear wins
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      single_cnt_o <= '0;
      double_cnt_o <= '0;
    end else if (cnt_clear_i) begin
      single_cnt_o <= '0;
      double_cnt_o <= '0;
    end else begin
      if (out_fire && err_single_o && (single_cnt_o != '1)) begin
        single_cnt_o <= single_cnt_o + 1'b1;
      end
      if (out_fire && err_double_o && (double_cnt_o != '1)) begin
        double_cnt_o <= double_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
